// File: rtl/ddr_rx_2to5.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_rx_2to5
//  Description : Receive gearbox for the 2-lane 10:1 DDR link. Recovers the
//                block boundary from a training marker, de-interleaves the
//                lanes and re-emits each 20-word block as 4 beats of 5 words.
//  Revision    : 1.0  initial release
// ============================================================================
module ddr_rx_2to5 #(
    parameter int                WORD_W     = 14,
    parameter logic [WORD_W-1:0] MARK_WORD  = 'h2A5A,
    parameter int                LOCK_COUNT = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0][9:0][WORD_W-1:0]    in_data,
    input  logic                           in_valid,
    input  logic                           align_restart,
    output logic [4:0][WORD_W-1:0]         data_out,
    output logic                           data_valid,
    output logic                           aligned,
    output logic [4:0]                     align_offset,
    output logic                           overrun
);

    localparam logic [7:0] c_lock_target = LOCK_COUNT[7:0];

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                      r_state;
    logic [7:0]                  r_hit_cnt;
    logic [4:0]                  r_offset;
    logic                        r_aligned;
    logic [19:0][WORD_W-1:0]     r_prev;
    logic [19:0][WORD_W-1:0]     r_blk;
    logic [2:0]                  r_left;
    logic [1:0]                  r_chunk;
    logic [4:0][WORD_W-1:0]      r_data_out;
    logic                        r_data_valid;
    logic [2:0]                  r_since;
    logic                        r_overrun;

    logic [19:0][WORD_W-1:0]     w_cur;
    logic [4:0]                  w_hit_num;
    logic [4:0]                  w_hit_idx;
    logic                        w_hit_at_p;
    logic [39:0][WORD_W-1:0]     w_window;
    logic [39:0][WORD_W-1:0]     w_win_shift;
    logic [19:0][WORD_W-1:0]     w_aligned;
    logic [19:0][WORD_W-1:0]     w_burst_shift;
    logic [4:0][WORD_W-1:0]      w_chunk;
    logic                        w_start;

    // De-interleave lanes into stream order: s(2k+lane) = in_data[lane][k]
    always_comb begin
        w_cur = '0;
        for (int k = 0; k < 10; k++) begin
            for (int lane = 0; lane < 2; lane++) begin
                w_cur[2*k+lane] = in_data[lane][k];
            end
        end
    end

    // Marker scan over the current block: hit count and last hit position
    always_comb begin
        w_hit_num = '0;
        w_hit_idx = '0;
        for (int i = 0; i < 20; i++) begin
            if (w_cur[i] == MARK_WORD) begin
                w_hit_num = w_hit_num + 5'd1;
                w_hit_idx = 5'(i);
            end
        end
    end

    assign w_hit_at_p = (w_cur[r_offset] == MARK_WORD);

    // Two-block window with the previous block in the low words, so a right
    // shift by p words yields the aligned block directly.
    assign w_window      = {w_cur, r_prev};
    assign w_win_shift   = w_window >> (32'(r_offset) * WORD_W);
    assign w_aligned     = w_win_shift[19:0];
    assign w_burst_shift = r_blk >> (32'(r_chunk) * 5 * WORD_W);
    assign w_chunk       = w_burst_shift[4:0];

    // Restart wins over a coincident block, which is then only stored
    assign w_start = in_valid && !align_restart && (r_state == ST_LOCKED);

    // Alignment FSM: search for a unique marker, verify it, then lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SEARCH;
            r_hit_cnt <= '0;
            r_offset  <= '0;
            r_aligned <= 1'b0;
        end else if (align_restart) begin
            r_state   <= ST_SEARCH;
            r_hit_cnt <= '0;
            r_aligned <= 1'b0;
        end else if (in_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_hit_num == 5'd1) begin
                        r_offset  <= w_hit_idx;
                        r_hit_cnt <= 8'd1;
                        if (c_lock_target == 8'd1) begin
                            r_state   <= ST_LOCKED;
                            r_aligned <= 1'b1;
                        end else begin
                            r_state   <= ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (w_hit_at_p) begin
                        r_hit_cnt <= r_hit_cnt + 8'd1;
                        if (r_hit_cnt + 8'd1 == c_lock_target) begin
                            r_state   <= ST_LOCKED;
                            r_aligned <= 1'b1;
                        end
                    end else begin
                        r_state   <= ST_SEARCH;
                        r_hit_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    r_state <= ST_LOCKED;
                end
                default: begin
                    r_state   <= ST_SEARCH;
                    r_hit_cnt <= '0;
                    r_aligned <= 1'b0;
                end
            endcase
        end
    end

    // Keep the last received block as the lower half of the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else if (in_valid) begin
            r_prev <= w_cur;
        end
    end

    // Burst engine: capture aligned block, then emit 4 beats of 5 words;
    // a new block restarts the schedule, truncating any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk        <= '0;
            r_left       <= '0;
            r_chunk      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (align_restart) begin
            r_left       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (r_left != 3'd0) begin
                r_data_out   <= w_chunk;
                r_data_valid <= 1'b1;
                r_chunk      <= r_chunk + 2'd1;
                r_left       <= r_left - 3'd1;
            end else begin
                r_data_valid <= 1'b0;
            end
            if (w_start) begin
                r_blk   <= w_aligned;
                r_left  <= 3'd4;
                r_chunk <= 2'd0;
            end
        end
    end

    // Block-spacing monitor: cycles since last strobe, saturating at 7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_since   <= 3'd7;
            r_overrun <= 1'b0;
        end else if (in_valid) begin
            r_since   <= 3'd1;
            r_overrun <= (r_since < 3'd4);
        end else begin
            r_since   <= (r_since == 3'd7) ? 3'd7 : r_since + 3'd1;
            r_overrun <= 1'b0;
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign aligned      = r_aligned;
    assign align_offset = r_offset;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire
